// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite row fetch path.
// Sprites are 15x15 pixels at 2 bits per pixel; pixel value 0 is transparent.
package sprite_pkg;

   localparam int SPRITE_W      = 15;
   localparam int SPRITE_H      = 15;
   localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;
   localparam int PIX_W         = 2;
   localparam int COL_W         = 4;

   typedef logic [PIX_W-1:0] pixel_t;

   localparam pixel_t PIX_TRANSPARENT = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      COMMIT
   } fetch_state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// Fill buffer written column by column during a fetch, copied whole into the
// display buffer on commit, plus the renderer's registered column read port.
module sprite_line_buffer
   import sprite_pkg::*;
(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             fill_clr,
   input  logic             fill_we,
   input  logic [COL_W-1:0] fill_col,
   input  pixel_t           fill_data,
   input  logic             commit,
   input  logic [COL_W-1:0] pix_col,
   output pixel_t           pix_out,
   output logic             pix_opaque
);

   pixel_t fill    [SPRITE_W];
   pixel_t display [SPRITE_W];
   pixel_t pix_nxt;

   // Columns past the sprite edge read as transparent.
   always_comb begin
      pix_nxt = PIX_TRANSPARENT;
      if (pix_col < COL_W'(SPRITE_W)) begin
         pix_nxt = display[pix_col];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < SPRITE_W; i++) begin
            fill[i]    <= PIX_TRANSPARENT;
            display[i] <= PIX_TRANSPARENT;
         end
         pix_out    <= PIX_TRANSPARENT;
         pix_opaque <= 1'b0;
      end else begin
         if (fill_clr) begin
            for (int i = 0; i < SPRITE_W; i++) begin
               fill[i] <= PIX_TRANSPARENT;
            end
         end else if (fill_we) begin
            fill[fill_col] <= fill_data;
         end
         // Reads at the commit edge still see the old display row.
         if (commit) begin
            for (int i = 0; i < SPRITE_W; i++) begin
               display[i] <= fill[i];
            end
         end
         pix_out    <= pix_nxt;
         pix_opaque <= (pix_nxt != PIX_TRANSPARENT);
      end
   end

endmodule

// File: rtl/sprite_row_fetcher.sv
// Streams one sprite row from a registered-read sprite RAM into a fill buffer
// and commits it atomically to the display line buffer used by the renderer.
module sprite_row_fetcher
   import sprite_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic [3:0]        row,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rd_address,
   input  pixel_t            rd_data,
   input  logic [3:0]        pix_col,
   output pixel_t            pix_out,
   output logic              pix_opaque
);

   fetch_state_t      state, state_nxt;
   logic [COL_W-1:0]  issue_cnt;
   logic [COL_W-1:0]  cap_cnt;
   logic              accept;
   logic              fill_we;
   logic              fill_clr;
   logic              commit;
   logic [ADDR_W-1:0] row_base;

   assign row_base = ADDR_W'(row) * ADDR_W'(SPRITE_W);
   assign busy     = (state != IDLE) || done;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The done cycle is spent in IDLE but still counts as busy, so start is held off.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fill_we   = 1'b0;
      fill_clr  = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept = 1'b1;
               if (row < COL_W'(SPRITE_H)) begin
                  state_nxt = FETCH;
               end else begin
                  state_nxt = COMMIT;
                  fill_clr  = 1'b1;
               end
            end
         end
         FETCH: begin
            // Read data trails the address by one edge, so capture starts at the second issue.
            fill_we = (issue_cnt >= COL_W'(2));
            if (issue_cnt == COL_W'(SPRITE_W)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            fill_we   = 1'b1;
            state_nxt = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_address <= '0;
         issue_cnt  <= '0;
         cap_cnt    <= '0;
         done       <= 1'b0;
      end else begin
         done <= commit;
         if (accept && (state_nxt == FETCH)) begin
            rd_address <= row_base;
            issue_cnt  <= COL_W'(1);
            cap_cnt    <= '0;
         end else if ((state == FETCH) && (issue_cnt < COL_W'(SPRITE_W))) begin
            rd_address <= rd_address + ADDR_W'(1);
            issue_cnt  <= issue_cnt + COL_W'(1);
         end
         if (fill_we) begin
            cap_cnt <= cap_cnt + COL_W'(1);
         end
      end
   end

   sprite_line_buffer u_line_buffer (
      .Clk        (Clk),
      .Reset      (Reset),
      .fill_clr   (fill_clr),
      .fill_we    (fill_we),
      .fill_col   (cap_cnt),
      .fill_data  (rd_data),
      .commit     (commit),
      .pix_col    (pix_col),
      .pix_out    (pix_out),
      .pix_opaque (pix_opaque)
   );

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Scoreboard bench for sprite_row_fetcher: stimulus queues expected row fetches,
// a monitor checks addresses, latency, busy/done and every renderer pixel read.
module tb_sprite_row_fetcher;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       start;
   logic [3:0] row;
   logic       busy;
   logic       done;
   logic [7:0] rd_address;
   logic [1:0] rd_data;
   logic [3:0] pix_col;
   logic [1:0] pix_out;
   logic       pix_opaque;

   sprite_row_fetcher dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .start      (start),
      .row        (row),
      .busy       (busy),
      .done       (done),
      .rd_address (rd_address),
      .rd_data    (rd_data),
      .pix_col    (pix_col),
      .pix_out    (pix_out),
      .pix_opaque (pix_opaque)
   );

   always #5 Clk = ~Clk;

   // Sprite RAM with a one-cycle registered read.
   logic [1:0] mem [225];
   always @(posedge Clk) rd_data <= (rd_address < 8'd225) ? mem[rd_address] : 2'b00;

   typedef struct {
      bit          valid;
      int          base;
      int          lat;
      logic [29:0] pix;
   } fetch_t;

   fetch_t     fq[$];
   logic [1:0] disp_m [15];
   bit         cur_act = 0;
   int         total = 0;
   int         bad = 0;
   bit         col_rand = 0;
   logic [3:0] col_fixed = 4'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      pix_col = 4'd0;
      forever begin
         @(negedge Clk);
         pix_col = col_rand ? 4'($urandom) : col_fixed;
      end
   end

   // Monitor / scoreboard
   initial begin
      bit         pbusy = 0;
      int         idx = 0;
      int         rise_cyc = 0;
      int         cyc = 0;
      logic [3:0] col;
      logic [1:0] expv;
      bit         rst_now;
      logic [7:0] paddr = 8'd0;
      fetch_t     cur;
      for (int k = 0; k < 15; k++) disp_m[k] = 2'b00;
      forever begin
         @(posedge Clk);
         cyc++;
         col     = pix_col;
         rst_now = Reset;
         expv    = (col < 4'd15) ? disp_m[col] : 2'b00;
         #1;
         if (rst_now) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_rd_address", rd_address, 0);
            check("rst_pix_out", pix_out, 0);
            check("rst_pix_opaque", pix_opaque, 0);
            for (int k = 0; k < 15; k++) disp_m[k] = 2'b00;
            cur_act = 0;
            pbusy   = 0;
         end else begin
            check("pix_out", pix_out, expv);
            check("pix_opaque", pix_opaque, (expv != 2'b00));
            if (busy && !pbusy) begin
               if (fq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_fetch busy=%0d required=0 at %0t", busy, $time);
               end else begin
                  cur      = fq.pop_front();
                  cur_act  = 1;
                  idx      = 0;
                  rise_cyc = cyc;
               end
            end
            if (cur_act) begin
               check("busy_active", busy, 1);
               if (cur.valid && idx < 15) check("rd_address", rd_address, cur.base + idx);
               if (!cur.valid) check("rd_address_hold", rd_address, paddr);
               if (done) begin
                  check("latency", cyc - rise_cyc, cur.lat);
                  for (int k = 0; k < 15; k++) disp_m[k] = cur.pix[2*k +: 2];
                  cur_act = 0;
               end
               idx++;
            end else begin
               check("done_idle", done, 0);
               if (!busy || pbusy) check("busy_idle", busy, 0);
            end
            pbusy = busy;
         end
         paddr = rd_address;
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (busy && n < 100) begin
         @(negedge Clk);
         n++;
      end
      if (busy) begin
         total++; bad++;
         $display("FAIL idle_timeout busy=%0d required=0 at %0t", busy, $time);
      end
   endtask

   task automatic fetch(input int r, input bit wait_done);
      fetch_t e;
      wait_idle();
      e.valid = (r < 15);
      e.base  = r * 15;
      e.lat   = e.valid ? 17 : 1;
      e.pix   = '0;
      for (int k = 0; k < 15; k++) e.pix[2*k +: 2] = e.valid ? mem[r*15 + k] : 2'b00;
      fq.push_back(e);
      start = 1'b1;
      row   = 4'(r);
      @(negedge Clk);
      start = 1'b0;
      row   = 4'($urandom);
      if (wait_done) wait_idle();
   endtask

   task automatic sweep();
      col_rand = 0;
      for (int c = 0; c < 16; c++) begin
         col_fixed = 4'(c);
         @(negedge Clk);
      end
      @(negedge Clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      start = 1'b0;
      row   = 4'd0;
      for (int i = 0; i < 225; i++) mem[i] = 2'(i % 4);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      check("init_busy", busy, 0);
      check("init_done", done, 0);
      check("init_rd_address", rd_address, 0);
      sweep();

      fetch(0, 1);
      sweep();
      fetch(14, 1);
      sweep();
      fetch(15, 1);
      sweep();

      fetch(2, 1);
      col_fixed = 4'd2;
      fetch(3, 0);
      repeat (4) @(negedge Clk);
      start = 1'b1;
      row   = 4'd7;
      @(negedge Clk);
      start = 1'b0;
      wait_idle();
      sweep();

      fetch(5, 0);
      repeat (7) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      wait_idle();
      sweep();
      fetch(1, 1);
      sweep();

      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 225; i++) mem[i] = 2'($urandom);
         col_rand = 1;
         fetch($urandom_range(0, 15), 1);
         repeat ($urandom_range(0, 3)) @(negedge Clk);
      end
      fetch(9, 0);
      fetch(4, 1);
      sweep();

      repeat (3) @(negedge Clk);
      check("queue_drained", fq.size(), 0);
      check("no_open_fetch", cur_act, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_row_fetcher.md
Name: sprite_row_fetcher

Overview:
Read-side companion to the 15x15, 2-bit-per-pixel sprite memories. On request, it streams one sprite row out of a sprite memory's registered read port into a fill buffer. It then commits that row atomically to a display line buffer, which the pixel renderer indexes by column. It sits between the sprite RAMs and the per-pixel colour mux, and hides the one-cycle memory read latency from the renderer.

Parameters:
SPRITE_W, 15, pixels per sprite row
SPRITE_H, 15, rows per sprite
PIX_W, 2, bits per pixel (palette index; 0 = transparent)
ADDR_W, 8, sprite memory address width (covers 0..224)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
start  in  1  request a row fetch; sampled only in IDLE
row  in  4  sprite row index to fetch, sampled with start
busy  out  1  high while a fetch is in progress
done  out  1  single-cycle pulse when new row is committed to display buffer
rd_address  out  ADDR_W  registered read address to sprite memory
rd_data  in  PIX_W  sprite memory read data, valid the cycle after address is sampled
pix_col  in  4  renderer column select into display buffer
pix_out  out  PIX_W  registered pixel at pix_col, 1-cycle latency
pix_opaque  out  1  registered, high when pix_out != 0

Behaviour:
- Interface decided: one clock Clk; Reset synchronous, active-high.
- Reset (any state, including mid-fetch):
  - FSM -> IDLE; busy=0, done=0, rd_address=0, pix_out=0, pix_opaque=0.
  - Column counters cleared.
  - Fill and display buffers cleared to all 0 (transparent).
- FSM states: IDLE, FETCH, DRAIN, COMMIT.
- IDLE:
  - start=1 and row<SPRITE_H at edge E0 -> FETCH; rd_address<=row*SPRITE_W; issue count<=1; capture count<=0.
  - start=1 and row>=SPRITE_H -> COMMIT with fill buffer forced to all 0.
- FETCH:
  - Each edge: rd_address<=rd_address+1 until SPRITE_W addresses have been issued (base..base+14, presented in the cycles after E0..E14).
  - From E2 on, rd_data is written to fill[capture count] and capture count increments.
  - After the last address is issued -> DRAIN.
- DRAIN: capture the final pixel (fill[14] at E16) -> COMMIT.
- COMMIT: display<=fill in one edge; done=1 for exactly one cycle; -> IDLE.
- Latency: start at E0 -> done high in the cycle after E17 (18 cycles). Out-of-range row: done high after E1.
- busy is high from the cycle after start acceptance through the done cycle inclusive; busy=0 in IDLE.
- start while busy: ignored, no queuing; row is not re-sampled.
- Address arithmetic: row*SPRITE_W computed in ADDR_W bits. Maximum address is 224; no wrap is possible for valid rows.
- Display buffer changes only at COMMIT, so the renderer never sees a partially fetched row.
- Pixel read: pix_out<=display[pix_col] each edge. pix_col>=SPRITE_W yields pix_out<=0. pix_opaque<=(next pix_out != 0).
- Simultaneous COMMIT and pixel read: pix_out registered at the commit edge shows the old display value; the new value appears from the next edge.
- Back-to-back: start asserted in the cycle after done is accepted (IDLE reached).

Decomposition:
- Package sprite_pkg:
  - SPRITE_W, SPRITE_H, SPRITE_PIXELS=225
  - typedef pixel_t (logic [PIX_W-1:0]), PIX_TRANSPARENT=2'b00
  - typedef enum fetch_state_t {IDLE, FETCH, DRAIN, COMMIT}
- One natural sub-module, sprite_line_buffer: fill and display arrays, per-column write, commit copy, registered indexed read with out-of-range zeroing.
- The FSM and address generation stay in sprite_row_fetcher.

Test Plan:
- Reset: after Reset high for 2 cycles -> busy=0, done=0, rd_address=0, pix_out=0 for every pix_col 0..15.
- Row 0 fetch, memory model preloaded mem[i]=i%4 with 1-cycle registered read -> rd_address sequence 0..14, done at E17, then pix_col=k reads k%4 one cycle later; pix_opaque=0 at k=0,4,8,12.
- Row 14 fetch -> rd_address 210..224; pix_col=14 returns mem[224]; pix_col=15 returns 0.
- Row 15 (out of range) -> no new addresses, done after E1, all display pixels 0.
- Start pulsed at E5 during a row-3 fetch with row=7 -> ignored; addresses stay 45..59, one done pulse; display shows row 3. Mid-fetch, pix_col=2 keeps returning the previous row's value until commit.
- Reset asserted at E8 of a fetch -> next cycle busy=0, no done pulse, display all 0. A subsequent row-1 fetch completes normally with addresses 15..29.
